// File: rtl/uart_rx_fsm.sv
// UART receive control/datapath stage: 3-sample majority oversampling, frame
// sequencing, LSB-first deserialization and parity/stop checking.
module uart_rx_fsm #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [PRESCALE_W-1:0] edge_count,
  input  logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  cnt_enable,
  output logic                  disable_bit_count,
  output logic [DATA_W-1:0]     p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [PRESCALE_W-1:0] PS4  = PRESCALE_W'(4);
  localparam logic [PRESCALE_W-1:0] PS8  = PRESCALE_W'(8);
  localparam logic [PRESCALE_W-1:0] PS16 = PRESCALE_W'(16);
  localparam logic [PRESCALE_W-1:0] PS32 = PRESCALE_W'(32);
  localparam logic [PRESCALE_W-1:0] ONE  = PRESCALE_W'(1);

  state_t                  state;
  logic [PRESCALE_W-1:0]   prescale_q;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic [DATA_W-1:0]       shift_q;
  logic                    par_acc;
  logic                    perr;
  logic                    s0, s1, s2;
  logic                    maj_q;

  logic [PRESCALE_W-1:0]   half;
  logic                    active;
  logic                    prescale_legal;
  logic                    end_of_bit;
  logic                    at_s0, at_s1, at_s2;
  logic                    s0_d, s1_d, s2_d;
  logic                    maj_now;
  logic                    bit_val;
  logic                    abort;
  logic                    frame_ok;

  assign state_dbg = state;

  always_comb begin
    half           = prescale >> 1;
    active         = (state != IDLE);
    prescale_legal = (prescale == PS4) || (prescale == PS8) ||
                     (prescale == PS16) || (prescale == PS32);
    end_of_bit     = (edge_count == prescale - ONE);
    at_s0          = active && (edge_count == half - ONE);
    at_s1          = active && (edge_count == half);
    at_s2          = active && (edge_count == half + ONE);
    s0_d           = at_s0 ? rx_in : s0;
    s1_d           = at_s1 ? rx_in : s1;
    s2_d           = at_s2 ? rx_in : s2;
    maj_now        = (s0_d & s1_d) | (s1_d & s2_d) | (s0_d & s2_d);
    // At prescale 4 the last sample lands on end_of_bit, so the fresh vote
    // bypasses the majority register for that one cycle.
    bit_val        = at_s2 ? maj_now : maj_q;
    abort          = active && (!prescale_legal || (prescale != prescale_q));
    frame_ok       = bit_val & ~(perr & par_en_q);
  end

  // data_valid/par_err/stp_err are single-cycle strobes with no back-pressure:
  // a consumer must take p_data in the cycle data_valid is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      cnt_enable        <= 1'b0;
      disable_bit_count <= 1'b1;
      p_data            <= '0;
      data_valid        <= 1'b0;
      par_err           <= 1'b0;
      stp_err           <= 1'b0;
      prescale_q        <= '0;
      par_en_q          <= 1'b0;
      par_typ_q         <= 1'b0;
      shift_q           <= '0;
      par_acc           <= 1'b0;
      perr              <= 1'b0;
      s0                <= 1'b0;
      s1                <= 1'b0;
      s2                <= 1'b0;
      maj_q             <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      s0         <= s0_d;
      s1         <= s1_d;
      s2         <= s2_d;
      maj_q      <= maj_now;
      if (abort) begin
        state             <= IDLE;
        cnt_enable        <= 1'b0;
        disable_bit_count <= 1'b1;
        shift_q           <= '0;
        par_acc           <= 1'b0;
        perr              <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (!rx_in && prescale_legal) begin
              state             <= START;
              cnt_enable        <= 1'b1;
              disable_bit_count <= 1'b0;
              prescale_q        <= prescale;
              par_en_q          <= par_en;
              par_typ_q         <= par_typ;
              shift_q           <= '0;
              par_acc           <= 1'b0;
              perr              <= 1'b0;
            end
          end
          START: begin
            if (end_of_bit) begin
              if (bit_val) begin
                state             <= IDLE;
                cnt_enable        <= 1'b0;
                disable_bit_count <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (end_of_bit) begin
              shift_q <= {bit_val, shift_q[DATA_W-1:1]};
              par_acc <= par_acc ^ bit_val;
              if (bit_count == BIT_CNT_W'(DATA_W)) begin
                state <= par_en_q ? PARITY : STOP;
              end
            end
          end
          PARITY: begin
            if (end_of_bit) begin
              perr  <= bit_val ^ par_acc ^ par_typ_q;
              state <= STOP;
            end
          end
          STOP: begin
            if (end_of_bit) begin
              state             <= IDLE;
              cnt_enable        <= 1'b0;
              disable_bit_count <= 1'b1;
              stp_err           <= ~bit_val;
              par_err           <= perr & par_en_q;
              data_valid        <= frame_ok;
              if (frame_ok) begin
                p_data <= shift_q;
              end
            end
          end
          default: begin
            state             <= IDLE;
            cnt_enable        <= 1'b0;
            disable_bit_count <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: models the upstream edge/bit counter, drives serial
// frames and scores the strobed results against an expected queue.
module tb_uart_rx_fsm;

  logic       clk;
  logic       rst;
  logic       rx_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic [5:0] edge_count;
  logic [3:0] bit_count;
  logic       cnt_enable;
  logic       disable_bit_count;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;
  logic [2:0] state_dbg;

  int checks;
  int errors;
  int cyc;
  int start_cyc;
  logic lat_chk;
  logic [7:0] model_pd;
  logic [10:0] exp_q[$];

  uart_rx_fsm #(.DATA_W(8), .PRESCALE_W(6), .BIT_CNT_W(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .rx_in            (rx_in),
    .prescale         (prescale),
    .par_en           (par_en),
    .par_typ          (par_typ),
    .edge_count       (edge_count),
    .bit_count        (bit_count),
    .cnt_enable       (cnt_enable),
    .disable_bit_count(disable_bit_count),
    .p_data           (p_data),
    .data_valid       (data_valid),
    .par_err          (par_err),
    .stp_err          (stp_err),
    .state_dbg        (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // upstream edge_bit_counter model
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (!cnt_enable) begin
      edge_count <= '0;
      bit_count  <= '0;
    end else if (edge_count == prescale - 6'd1) begin
      edge_count <= '0;
      bit_count  <= disable_bit_count ? 4'd0 : bit_count + 4'd1;
    end else begin
      edge_count <= edge_count + 6'd1;
      if (disable_bit_count) bit_count <= '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare any strobe against the oldest expected frame result
  task automatic mon();
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {data_valid, par_err, stp_err, p_data};
    if (data_valid || par_err || stp_err) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", 32'(obs), 32'(0));
      end else begin
        exp = exp_q.pop_front();
        chk("frame_result", 32'(obs), 32'(exp));
        if (lat_chk) begin
          chk("frame_len", 32'(cyc - start_cyc), 32'(80));
          lat_chk = 1'b0;
        end
      end
    end
  endtask

  // driver tasks
  task automatic step(input logic v);
    rx_in = v;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    mon();
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b1);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic pbit, input logic stop_b);
    logic pe;
    logic dv;
    pe = pen & (pbit ^ (^d) ^ ptyp);
    dv = stop_b & ~pe;
    if (dv) model_pd = d;
    exp_q.push_back({dv, pe, ~stop_b, model_pd});
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stop_b, input int noise_bit, input int max_bits);
    logic [11:0] fb;
    int nb;
    int p;
    logic v;
    p = int'(prescale);
    fb = '1;
    fb[0] = 1'b0;
    for (int i = 0; i < 8; i++) fb[i+1] = d[i];
    nb = 9;
    if (pen) begin
      fb[9] = pbit;
      nb = 10;
    end
    fb[nb] = stop_b;
    nb = nb + 1;
    if (max_bits < nb) nb = max_bits;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < p; c++) begin
        v = fb[i];
        if (i == noise_bit && c == 5) v = ~v;
        step(v);
        if (i == 0 && c == 0) start_cyc = cyc;
      end
    end
  endtask

  initial begin
    rst = 1'b0; rx_in = 1'b1; prescale = 6'd8; par_en = 1'b0; par_typ = 1'b0;
    checks = 0; errors = 0; cyc = 0; start_cyc = 0; lat_chk = 1'b0; model_pd = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_dbg), 32'(0));
    chk("rst_cnt_enable", 32'(cnt_enable), 32'(0));
    chk("rst_disable", 32'(disable_bit_count), 32'(1));
    chk("rst_p_data", 32'(p_data), 32'(0));
    chk("rst_strobes", 32'({data_valid, par_err, stp_err}), 32'(0));
    rst = 1'b1;
    idle(4);

    // prescale 8, no parity, 0xA5, frame length checked
    lat_chk = 1'b1;
    expect_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, 12);
    idle(6);
    chk("pending_a5", 32'(exp_q.size()), 32'(0));
    chk("lat_seen", 32'(lat_chk), 32'(0));
    chk("idle_cnt_enable", 32'(cnt_enable), 32'(0));
    chk("idle_disable", 32'(disable_bit_count), 32'(1));

    // prescale 16, even parity: good, then bad parity, then odd parity good
    prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
    expect_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, 12);
    idle(6);
    expect_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, 12);
    idle(6);
    par_typ = 1'b1;
    expect_frame(8'h3D, 1'b1, 1'b1, 1'b0, 1'b1);
    send_frame(8'h3D, 1'b1, 1'b0, 1'b1, -1, 12);
    idle(6);
    chk("pending_parity", 32'(exp_q.size()), 32'(0));

    // prescale 4: stop error, then a good frame
    prescale = 6'd4; par_en = 1'b0; par_typ = 1'b0;
    expect_frame(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h77, 1'b0, 1'b0, 1'b0, -1, 12);
    idle(6);
    expect_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, -1, 12);
    idle(6);
    chk("pending_p4", 32'(exp_q.size()), 32'(0));

    // start-bit glitch at prescale 16
    prescale = 6'd16;
    step(1'b0);
    step(1'b0);
    idle(30);
    chk("glitch_state", 32'(state_dbg), 32'(0));
    chk("glitch_disable", 32'(disable_bit_count), 32'(1));
    chk("glitch_cnt_enable", 32'(cnt_enable), 32'(0));

    // prescale changed mid-DATA aborts the frame
    prescale = 6'd32;
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, 4);
    prescale = 6'd8;
    step(1'b1);
    chk("abort_state", 32'(state_dbg), 32'(0));
    chk("abort_cnt_enable", 32'(cnt_enable), 32'(0));
    idle(20);
    expect_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, -1, 12);
    idle(6);
    chk("pending_abort", 32'(exp_q.size()), 32'(0));

    // single-sample noise on data bit 2 is voted out
    expect_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 3, 12);
    idle(6);

    // back-to-back frames with no idle gap
    expect_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h00, 1'b0, 1'b0, 1'b1, -1, 12);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1, -1, 12);
    idle(12);
    chk("pending_b2b", 32'(exp_q.size()), 32'(0));
    chk("b2b_p_data", 32'(p_data), 32'(8'hFF));

    // reset asserted mid-frame
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, -1, 5);
    rst = 1'b0;
    #1;
    chk("midrst_state", 32'(state_dbg), 32'(0));
    chk("midrst_cnt_enable", 32'(cnt_enable), 32'(0));
    chk("midrst_disable", 32'(disable_bit_count), 32'(1));
    chk("midrst_p_data", 32'(p_data), 32'(0));
    chk("midrst_strobes", 32'({data_valid, par_err, stp_err}), 32'(0));
    model_pd = 8'h00;
    @(negedge clk);
    rst = 1'b1;
    idle(4);
    expect_frame(8'h3E, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h3E, 1'b0, 1'b0, 1'b1, -1, 12);
    idle(6);

    // final report
    chk("pending_final", 32'(exp_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
